// File: rtl/slave_responder_if.sv
// Request/acknowledge bus between the interconnect (master) and one slave.
interface slave_responder_if;
  logic        req;
  logic        cmd;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;
  logic        busy;

  modport master (
    output req, cmd, addr, wdata,
    input  ack, rdata, busy
  );

  modport slave (
    input  req, cmd, addr, wdata,
    output ack, rdata, busy
  );
endinterface

// File: rtl/slave_responder.sv
// Slave end of the request/ack bus: captures one request at a time, acks it
// after ACK_DELAY idle cycles, writes into a local word memory and returns
// read data one cycle after the ack. rdata is zero outside the data cycle so
// the interconnect can OR several slaves together.
//
// state  | meaning
// IDLE   | waiting for req; captures cmd/index/wdata when it arrives
// WAIT   | counting down ACK_DELAY cycles
// ACK    | ack high for one cycle; writes commit at the end of this cycle
// DATA   | read data driven on rdata for one cycle
module slave_responder #(
  parameter int MEM_AW    = 4,
  parameter int ACK_DELAY = 2
) (
  input  logic             clk,
  input  logic             rst,
  slave_responder_if.slave bus
);

  localparam int          DEPTH = 2 ** MEM_AW;
  localparam logic [3:0]  DLY   = 4'(ACK_DELAY);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_DATA} state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                cmd_q, cmd_d;
  logic [MEM_AW-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                ack_q, ack_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                busy_q, busy_d;
  logic [31:0]         mem_q [DEPTH];
  logic [31:0]         mem_d [DEPTH];

  // Address bits outside the word index are deliberately ignored (aliasing).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr[31:MEM_AW+2], bus.addr[1:0]};

  // Next-state, capture, memory write and registered output decode.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    mem_d   = mem_q;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          cmd_d   = bus.cmd;
          idx_d   = bus.addr[MEM_AW+1:2];
          wdata_d = bus.wdata;
          cnt_d   = DLY;
          state_d = (DLY != 4'd0) ? S_WAIT : S_ACK;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = S_ACK;
      end
      S_ACK: begin
        if (cmd_q) begin
          mem_d[idx_q] = wdata_q;
          state_d      = S_IDLE;
        end else begin
          state_d = S_DATA;
        end
      end
      S_DATA: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ack_d   = (state_d == S_ACK);
    busy_d  = (state_d != S_IDLE);
    rdata_d = (state_d == S_DATA) ? mem_q[idx_q] : 32'h0;
  end

  // State, capture registers, outputs and memory; reset abandons any transaction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      cmd_q   <= 1'b0;
      idx_q   <= '0;
      wdata_q <= 32'h0;
      ack_q   <= 1'b0;
      rdata_q <= 32'h0;
      busy_q  <= 1'b0;
      mem_q   <= '{default: 32'h0};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
      busy_q  <= busy_d;
      mem_q   <= mem_d;
    end
  end

  assign bus.ack   = ack_q;
  assign bus.rdata = rdata_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_slave_responder.sv
// Bench for slave_responder: two instances (ACK_DELAY 2 and 0). Stimulus pushes
// expected transactions into a scoreboard; a negedge monitor checks ack, busy
// and rdata on every cycle against the active expectation.
module tb_slave_responder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  slave_responder_if m0 ();
  slave_responder_if m1 ();

  slave_responder #(.MEM_AW(4), .ACK_DELAY(2)) u_dut0 (.clk(clk), .rst(rst), .bus(m0.slave));
  slave_responder #(.MEM_AW(4), .ACK_DELAY(0)) u_dut1 (.clk(clk), .rst(rst), .bus(m1.slave));

  typedef struct {
    int          dut;
    int          t;
    int          dly;
    bit          rd;
    logic [31:0] data;
  } item_t;

  item_t sbq[$];
  item_t cur[2];
  bit    cur_v[2];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cyc, act, exp);
    end
  endtask

  task automatic mon_step(input int d, input logic a, input logic b, input logic [31:0] r);
    logic        e_ack, e_busy;
    logic [31:0] e_rd;
    int          last;
    if (rst) cur_v[d] = 1'b0;
    else if (!cur_v[d] && sbq.size() > 0 && sbq[0].dut == d && cyc == sbq[0].t + 1) begin
      cur[d]   = sbq.pop_front();
      cur_v[d] = 1'b1;
    end
    last   = cur[d].t + 1 + cur[d].dly + (cur[d].rd ? 1 : 0);
    e_ack  = cur_v[d] && (cyc == cur[d].t + 1 + cur[d].dly);
    e_busy = cur_v[d] && (cyc <= last);
    e_rd   = (cur_v[d] && cur[d].rd && cyc == cur[d].t + 2 + cur[d].dly) ? cur[d].data : 32'h0;
    chk("ack", d, {31'b0, a}, {31'b0, e_ack});
    chk("busy", d, {31'b0, b}, {31'b0, e_busy});
    chk("rdata", d, r, e_rd);
    if (cur_v[d] && cyc >= last) cur_v[d] = 1'b0;
  endtask

  // Monitor: sample both DUTs away from the rising edge.
  always @(negedge clk) begin
    mon_step(0, m0.ack, m0.busy, m0.rdata);
    mon_step(1, m1.ack, m1.busy, m1.rdata);
  end

  task automatic set_bus(input int d, input logic r, input logic c, input logic [31:0] a, input logic [31:0] w);
    if (d == 0) begin
      m0.req = r; m0.cmd = c; m0.addr = a; m0.wdata = w;
    end else begin
      m1.req = r; m1.cmd = c; m1.addr = a; m1.wdata = w;
    end
  endtask

  // Called #1 after a rising edge with the DUT in IDLE; returns likewise.
  task automatic txn(input int d, input logic c, input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] ed, input bit perturb);
    item_t it;
    it.dut  = d;
    it.t    = cyc;
    it.dly  = (d == 0) ? 2 : 0;
    it.rd   = !c;
    it.data = ed;
    sbq.push_back(it);
    set_bus(d, 1'b1, c, a, wd);
    repeat (1 + it.dly) begin
      @(posedge clk); #1;
      if (perturb && it.dly > 0 && cyc == it.t + 1) set_bus(d, 1'b0, ~c, 32'h10, 32'hBAD0BAD0);
    end
    if (!perturb) set_bus(d, 1'b0, c, a, wd);
    if (!c) begin @(posedge clk); #1; end
    @(posedge clk); #1;
  endtask

  initial begin
    set_bus(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_bus(1, 1'b0, 1'b0, 32'h0, 32'h0);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // Reset in WAIT of a write: everything drops at once, write never lands.
    set_bus(0, 1'b1, 1'b1, 32'h8, 32'hDEADBEEF);
    @(posedge clk); #1;
    chk("busy_before_rst", 0, {31'b0, m0.busy}, 32'h1);
    set_bus(0, 1'b0, 1'b1, 32'h8, 32'hDEADBEEF);
    rst = 1'b1;
    #1;
    chk("ack_in_rst", 0, {31'b0, m0.ack}, 32'h0);
    chk("busy_in_rst", 0, {31'b0, m0.busy}, 32'h0);
    chk("rdata_in_rst", 0, m0.rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    txn(0, 1'b0, 32'h8, 32'h0, 32'h0, 1'b0);

    // Write then read back with ACK_DELAY = 2.
    txn(0, 1'b1, 32'h8, 32'hDEADBEEF, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b0);

    // Aliasing: 0x44 and 0x04 map to the same word.
    txn(0, 1'b1, 32'h44, 32'h12345678, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h04, 32'h0, 32'h12345678, 1'b0);

    // Request fields changed and req dropped during WAIT.
    txn(0, 1'b0, 32'h8, 32'h0, 32'hDEADBEEF, 1'b1);
    txn(0, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0);

    // Back-to-back write then read of the same word.
    txn(0, 1'b1, 32'h3C, 32'hA5A5A5A5, 32'h0, 1'b0);
    txn(0, 1'b0, 32'h3C, 32'h0, 32'hA5A5A5A5, 1'b0);

    // ACK_DELAY = 0 instance.
    txn(1, 1'b0, 32'h3C, 32'h0, 32'h0, 1'b0);
    txn(1, 1'b1, 32'h20, 32'h0000FFFF, 32'h0, 1'b0);
    txn(1, 1'b0, 32'h20, 32'h0, 32'h0000FFFF, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    chk("sb_drained", 0, 32'(sbq.size()), 32'h0);
    chk("txn_open", 0, {30'b0, cur_v[1], cur_v[0]}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
